// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: converter states,
// seven-segment codes and digit/iteration counts.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITER   = 14;

    localparam logic [13:0] BIN_MAX = 14'd9999;

    // Active-low {dp,g,f,e,d,c,b,a}; dp bit is always 1 (off)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary (saturated to 9999) to
// four BCD nibbles, one shift iteration per clock.
//   state | meaning
//   IDLE  | waiting for i_start
//   LOAD  | latch saturated input, clear scratch and iteration count
//   SHIFT | one add-3/shift-left iteration per cycle, BCD_ITER cycles
//   DONE  | o_bcd holds the result for one cycle (o_done high)
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_bin,
    input  logic        i_start,
    output logic [15:0] o_bcd,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [3:0] LAST_ITER = 4'(BCD_ITER - 1);

    conv_state_e state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] adj;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        adj     = bcd_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = LOAD;
            end
            LOAD: begin
                bin_d   = (i_bin > BIN_MAX) ? BIN_MAX : i_bin;
                bcd_d   = '0;
                iter_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_bcd  = bcd_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed seven-segment driver: converts i_count to BCD on
// change and scans the digits with a prescaled digit select.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_count,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data,
    output logic        o_busy
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   disp_q, disp_d;
    logic [13:0]   last_q, last_d;
    logic [13:0]   raw_q, raw_d;
    logic          busy_prev_q;
    logic [3:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic [15:0] conv_bcd;
    logic        conv_busy;
    logic        conv_done;
    logic [3:0]  blank;
    logic        seen_nz;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_bin   (i_count),
        .i_start (i_count != last_q),
        .o_bcd   (conv_bcd),
        .o_busy  (conv_busy),
        .o_done  (conv_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q     <= '0;
            digit_q     <= '0;
            disp_q      <= '0;
            last_q      <= '0;
            raw_q       <= '0;
            busy_prev_q <= 1'b0;
            com_q       <= 4'b1110;
            data_q      <= SEG_0;
        end else begin
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            disp_q      <= disp_d;
            last_q      <= last_d;
            raw_q       <= raw_d;
            busy_prev_q <= conv_busy;
            com_q       <= com_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (presc_q == DIV_LAST) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
        end

        // The raw value is latched on the same edge the converter samples it
        // (its LOAD cycle), so the change compare stays unsaturated.
        raw_d = raw_q;
        if (conv_busy && !busy_prev_q) raw_d = i_count;

        disp_d = disp_q;
        last_d = last_q;
        if (conv_done) begin
            disp_d = conv_bcd;
            last_d = raw_q;
        end

        blank   = '0;
        seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz  = seen_nz | (disp_q[4*i +: 4] != 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && !seen_nz;
        end

        com_d  = ~(4'b0001 << digit_q);
        data_d = blank[digit_q] ? SEG_BLANK : seg_encode(disp_q[{digit_q, 2'b00} +: 4]);
    end

    assign o_fnd_com  = com_q;
    assign o_fnd_data = data_q;
    assign o_busy     = conv_busy;

endmodule
